// File: rtl/s_dadda_mac4_acc.sv
// Signed 4x4 multiply-accumulate over bursts of LEN operand pairs, with a saturating
// accumulator and valid/ready handshakes on both sides.

module s_dadda_mul4s (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);
   // Modified Baugh-Wooley partial products; sign rows inverted, constant ones at bits 4 and 7.
   logic p00, p10, p01, p20, p11, p02, p21, p12, p22, p33;
   logic n30, n03, n31, n13, n32, n23;
   logic s1, k1, s2, k2, s3, k3, s4, k4, s5, k5, s6, k6;
   logic [7:0] x, y;
   logic [7:0] cy;

   assign p00 = a[0] & b[0];
   assign p10 = a[1] & b[0];
   assign p01 = a[0] & b[1];
   assign p20 = a[2] & b[0];
   assign p11 = a[1] & b[1];
   assign p02 = a[0] & b[2];
   assign p21 = a[2] & b[1];
   assign p12 = a[1] & b[2];
   assign p22 = a[2] & b[2];
   assign p33 = a[3] & b[3];
   assign n30 = ~(a[3] & b[0]);
   assign n03 = ~(a[0] & b[3]);
   assign n31 = ~(a[3] & b[1]);
   assign n13 = ~(a[1] & b[3]);
   assign n32 = ~(a[3] & b[2]);
   assign n23 = ~(a[2] & b[3]);

   // Dadda stage 1 (height 4 -> 3)
   assign {k1, s1} = {1'b0, n30} + {1'b0, p21};
   assign {k2, s2} = {1'b0, n31} + {1'b0, p22} + {1'b0, n13};
   // Dadda stage 2 (height 3 -> 2)
   assign {k3, s3} = {1'b0, p20} + {1'b0, p11};
   assign {k4, s4} = {1'b0, s1} + {1'b0, p12} + {1'b0, n03};
   assign {k5, s5} = 2'b01 + {1'b0, k1} + {1'b0, s2};
   assign {k6, s6} = {1'b0, n32} + {1'b0, n23} + {1'b0, k2};

   assign x = {1'b1, p33, s6, s5, s4, s3, p10, p00};
   assign y = {1'b0, k6, k5, k4, k3, p02, p01, 1'b0};

   always_comb begin
      p     = '0;
      cy    = '0;
      for (int i = 0; i < 7; i++) begin
         p[i]      = x[i] ^ y[i] ^ cy[i];
         cy[i + 1] = (x[i] & y[i]) | (cy[i] & (x[i] ^ y[i]));
      end
      p[7] = x[7] ^ y[7] ^ cy[7];
   end
endmodule

// state | meaning
// ACC   | accepting operands, accumulating registered products
// HOLD  | burst result presented on out_data until consumed
module s_dadda_mac4_acc #(
   parameter int ACC_W = 12,
   parameter int LEN   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       a,
   input  logic [3:0]       b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_ovf
);
   localparam logic [0:0] ST_ACC  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;
   localparam logic [7:0] LEN_C   = 8'(LEN);
   localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [0:0]       state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             pv_q, pv_d;
   logic [7:0]       prod_q, prod_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] out_data_q, out_data_d;
   logic             out_ovf_q, out_ovf_d;
   logic             up_q, up_d;

   logic [7:0]       prod_w;
   logic [ACC_W:0]   sum_w;
   logic             clip_w;
   logic [ACC_W-1:0] sat_w;
   logic             in_fire, out_fire;

   s_dadda_mul4s u_mul (
      .a (a),
      .b (b),
      .p (prod_w)
   );

   // One guard bit is enough: |prod| <= 64 is far below the accumulator range.
   assign sum_w  = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-7){prod_q[7]}}, prod_q};
   assign clip_w = sum_w[ACC_W] ^ sum_w[ACC_W-1];
   assign sat_w  = clip_w ? (sum_w[ACC_W] ? SAT_MIN : SAT_MAX) : sum_w[ACC_W-1:0];

   assign in_ready  = up_q && (state_q == ST_ACC) && (cnt_q < LEN_C);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid_q && out_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pv_d        = 1'b0;
      prod_d      = prod_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ovf_d   = out_ovf_q;
      up_d        = 1'b1;

      if (in_fire) begin
         prod_d = prod_w;
         pv_d   = 1'b1;
         cnt_d  = cnt_q + 8'd1;
      end
      if (pv_q) begin
         acc_d     = sat_w;
         out_ovf_d = out_ovf_q | clip_w;
         if (cnt_q == LEN_C) begin
            out_data_d  = sat_w;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
         end
      end
      if (state_q == ST_HOLD && out_fire) begin
         out_valid_d = 1'b0;
         acc_d       = '0;
         cnt_d       = '0;
         out_ovf_d   = 1'b0;
         state_d     = ST_ACC;
      end
      if (clr) begin
         pv_d        = 1'b0;
         acc_d       = '0;
         cnt_d       = '0;
         out_valid_d = 1'b0;
         out_ovf_d   = 1'b0;
         state_d     = ST_ACC;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACC;
         cnt_q       <= '0;
         pv_q        <= 1'b0;
         prod_q      <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
         up_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pv_q        <= pv_d;
         prod_q      <= prod_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ovf_q   <= out_ovf_d;
         up_q        <= up_d;
      end
   end
endmodule
